age_entry_alloc: RTL and testbench
==================================

# age_entry_alloc

Allocation and payload front end for the age-ordered issue structures. It owns the per-entry valid bits and the payload storage for up to NumEntries entries. Each cycle it accepts up to NumEnq packed requests from upstream, assigns each request a distinct free entry, and drives the enqueue side of the age tracker: enq_fire, one-hot enq_mask and entry_vld. It also frees the single entry selected by the downstream age selector and returns that entry's payload.

## Interface
- NumEntries, 4, number of entries; minimum 2.
- NumEnq, 2, enqueue lanes per cycle; range 1..NumEntries.
- DataWidth, 32, payload bits per entry.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NumEnq  per-lane request valid; must be packed, so lane j valid implies all lanes below j are valid.
- req_data_i  in  NumEnq x DataWidth  per-lane payload.
- req_ready_o  out  NumEnq  per-lane ready; lane j ready iff free entries > j.
- enq_fire_o  out  NumEnq  req_valid_i[j] & req_ready_o[j].
- enq_mask_o  out  NumEnq x NumEntries  one-hot entry assigned to lane j; all zero when lane j is not ready.
- deq_fire_i  in  1  release the entry in deq_mask_i this cycle.
- deq_mask_i  in  NumEntries  one-hot entry to release; must be a currently valid entry.
- deq_data_o  out  DataWidth  payload of the entry in deq_mask_i (combinational read of stored data).
- entry_vld_o  out  NumEntries  registered valid vector.
- count_o  out  $clog2(NumEntries+1)  registered occupancy count.
- full_o / empty_o  out  1 each  count_o == NumEntries / count_o == 0.

## Operation
- State:
  - vld_q[NumEntries], reset 0.
  - data_q[NumEntries][DataWidth], not reset.
  - cnt_q, reset 0.
- Free vector is ~vld_q. It uses registered state only; an entry released this cycle is not re-allocatable until the next cycle.
- Lane assignment is a priority scan:
  - Lane 0 takes the lowest-index free entry.
  - Lane j takes the lowest free entry not taken by lanes < j.
  - Masks are mutually disjoint and one-hot.
- Lane j is assigned an entry iff (NumEntries - cnt_q) > j, regardless of its valid.
- Enqueue of lane j on enq_fire_o[j]:
  - vld_q[entry] <= 1.
  - data_q[entry] <= req_data_i[j].
- Dequeue on deq_fire_i: vld_q[idx] <= 0, where idx is the set bit of deq_mask_i.
  - Dequeue does not touch data_q.
  - deq_data_o = OR over entries of (deq_mask_i[e] ? data_q[e] : 0), i.e. one-hot mux.
- Count update: cnt_q <= cnt_q + popcount(enq_fire_o) - deq_fire_i. The width holds 0..NumEntries with no wrap.
- Simultaneous enqueue and dequeue are both applied. Enqueue and dequeue target disjoint entries by construction.
- Full: all req_ready_o = 0 and enq_mask_o all zero. A dequeue in the same cycle does not raise ready until the next cycle.
- Empty: a dequeue is illegal. A deq_fire_i on an invalid entry is a protocol violation; behaviour is undefined, but vld_q stays 0 for that entry.
- Simulation-only assertions, disabled during reset:
  - enq_mask_o lanes are pairwise disjoint.
  - Every fired enq_mask_o hits an invalid entry.
  - deq_mask_i is onehot when deq_fire_i.
  - deq_mask_i & ~vld_q == 0 when deq_fire_i.
  - req_valid_i is packed.
  - cnt_q == popcount(vld_q).

## Timing
- Enqueue latency: the request is accepted in cycle N, and entry_vld_o/count_o reflect it in N+1. Data is readable via deq_data_o from N+1.
- req_ready_o, enq_fire_o and enq_mask_o are combinational from vld_q, cnt_q and req_valid_i. They have no path from deq_fire_i.
- deq_data_o is combinational from deq_mask_i and data_q, giving a same-cycle read. Release is visible in N+1.
- Reset asserted mid-operation: vld_q = 0, cnt_q = 0, full_o = 0, empty_o = 1 immediately (asynchronous). After reset all lanes are ready.
- No back-to-back restrictions; full throughput of NumEnq enqueues plus 1 dequeue per cycle.

## Test plan
- Reset, then 2 lanes valid with data 0xA0, 0xA1 -> enq_mask_o = {4'b0010, 4'b0001}, enq_fire_o = 2'b11; next cycle entry_vld_o = 4'b0011, count_o = 2.
- Entries 0..2 valid, both lanes valid -> req_ready_o = 2'b01, lane 0 mask 4'b1000; next cycle full_o = 1, req_ready_o = 2'b00.
- Full with deq_fire_i and deq_mask_i = 4'b0100 -> deq_data_o equals the stored payload, req_ready_o stays 0 that cycle; next cycle count_o = 3, lane 0 mask = 4'b0100.
- Entry 1 free, entry 0 valid, deq of entry 0 and lane 0 enqueue in the same cycle -> lane 0 gets 4'b0010, not 4'b0001; next cycle entry_vld_o = 4'b0010, count_o unchanged.
- Reset asserted while count_o = 3 -> entry_vld_o = 0, count_o = 0, empty_o = 1 before the next edge; after release, lane 0 mask = 4'b0001.
- Random packed enqueue and legal one-hot dequeue for 10k cycles -> every dequeued payload matches the scoreboard; count_o == popcount(entry_vld_o); no assertion fires.

Source files
------------

// File: rtl/age_entry_alloc.sv
// age_entry_alloc: entry allocation, payload storage and release for age-ordered issue.
// Ports: req_* enqueue lanes, enq_* allocation, deq_* release/read, entry_vld/count/full/empty status.
module age_entry_alloc #(
  parameter int NumEntries = 4,
  parameter int NumEnq = 2,
  parameter int DataWidth = 32,
  localparam int CntW = $clog2(NumEntries + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumEnq-1:0]                      req_valid_i,
  input  logic [NumEnq-1:0][DataWidth-1:0]       req_data_i,
  output logic [NumEnq-1:0]                      req_ready_o,
  output logic [NumEnq-1:0]                      enq_fire_o,
  output logic [NumEnq-1:0][NumEntries-1:0]      enq_mask_o,
  input  logic                                   deq_fire_i,
  input  logic [NumEntries-1:0]                  deq_mask_i,
  output logic [DataWidth-1:0]                   deq_data_o,
  output logic [NumEntries-1:0]                  entry_vld_o,
  output logic [CntW-1:0]                        count_o,
  output logic                                   full_o,
  output logic                                   empty_o
);

  logic [NumEntries-1:0]                 vld_q, vld_d;
  logic [NumEntries-1:0][DataWidth-1:0]  data_q, data_d;
  logic [CntW-1:0]                       cnt_q, cnt_d;

  // Priority scan over registered free entries; lane j only
  // gets an entry when enough free slots exist for it.
  always_comb begin : alloc
    logic [NumEntries-1:0] taken;
    logic found;
    int free_n;
    taken = '0;
    found = 1'b0;
    enq_mask_o = '0;
    req_ready_o = '0;
    free_n = NumEntries - int'(cnt_q);
    for (int j = 0; j < NumEnq; j++) begin
      if (free_n > j) begin
        req_ready_o[j] = 1'b1;
        found = 1'b0;
        for (int e = 0; e < NumEntries; e++) begin
          if (!vld_q[e] && !taken[e] && !found) begin
            enq_mask_o[j][e] = 1'b1;
            found = 1'b1;
          end
        end
        taken = taken | enq_mask_o[j];
      end
    end
  end

  assign enq_fire_o = req_valid_i & req_ready_o;

  always_comb begin : nxt
    logic [CntW-1:0] n_enq;
    n_enq = '0;
    vld_d = vld_q;
    data_d = data_q;
    if (deq_fire_i) vld_d = vld_d & ~deq_mask_i;
    for (int j = 0; j < NumEnq; j++) begin
      if (enq_fire_o[j]) begin
        vld_d = vld_d | enq_mask_o[j];
        n_enq = n_enq + CntW'(1);
        for (int e = 0; e < NumEntries; e++) begin
          if (enq_mask_o[j][e]) data_d[e] = req_data_i[j];
        end
      end
    end
    cnt_d = cnt_q + n_enq - CntW'(deq_fire_i);
  end

  always_comb begin
    deq_data_o = '0;
    for (int e = 0; e < NumEntries; e++) begin
      if (deq_mask_i[e]) deq_data_o = deq_data_o | data_q[e];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign entry_vld_o = vld_q;
  assign count_o = cnt_q;
  assign full_o = (cnt_q == CntW'(NumEntries));
  assign empty_o = (cnt_q == '0);

  logic a_disj, a_free, a_packed;
  always_comb begin
    a_disj = 1'b1;
    a_free = 1'b1;
    a_packed = 1'b1;
    for (int j = 0; j < NumEnq; j++) begin
      for (int k = j + 1; k < NumEnq; k++) begin
        if ((enq_mask_o[j] & enq_mask_o[k]) != '0) a_disj = 1'b0;
      end
      if (enq_fire_o[j] && (enq_mask_o[j] & vld_q) != '0) a_free = 1'b0;
    end
    for (int j = 1; j < NumEnq; j++) begin
      if (req_valid_i[j] && !req_valid_i[j-1]) a_packed = 1'b0;
    end
  end

  a_mask_disjoint: assert property (
    @(posedge clk_i) disable iff (!rst_ni) a_disj);
  a_enq_free: assert property (
    @(posedge clk_i) disable iff (!rst_ni) a_free);
  a_req_packed: assert property (
    @(posedge clk_i) disable iff (!rst_ni) a_packed);
  a_deq_onehot: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    deq_fire_i |-> $onehot(deq_mask_i));
  a_deq_valid: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    deq_fire_i |-> ((deq_mask_i & ~vld_q) == '0));
  a_cnt_match: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $countones(vld_q) == int'(cnt_q));

endmodule

// File: tb/tb_age_entry_alloc.sv
// tb_age_entry_alloc: directed scenarios plus a random scoreboard run.
// Drives age_entry_alloc with NumEntries=4, NumEnq=2, DataWidth=32.
module tb_age_entry_alloc;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_ready;
  logic [1:0]       enq_fire;
  logic [1:0][3:0]  enq_mask;
  logic             deq_fire;
  logic [3:0]       deq_mask;
  logic [31:0]      deq_data;
  logic [3:0]       entry_vld;
  logic [2:0]       count;
  logic             full;
  logic             empty;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] vld;
    logic [2:0] cnt;
  } exp_t;
  exp_t sb[$];

  age_entry_alloc #(
    .NumEntries(4),
    .NumEnq(2),
    .DataWidth(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .enq_fire_o(enq_fire),
    .enq_mask_o(enq_mask),
    .deq_fire_i(deq_fire),
    .deq_mask_i(deq_mask),
    .deq_data_o(deq_data),
    .entry_vld_o(entry_vld),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    req_valid = 2'b00;
    req_data = '0;
    deq_fire = 1'b0;
    deq_mask = 4'b0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    checks++;
    if (entry_vld !== 4'b0000) begin
      errors++;
      $display("FAIL rst_vld got %b exp 0000", entry_vld);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL rst_cnt got %0d exp 0", count);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", empty, full);
    end
    checks++;
    if (req_ready !== 2'b11) begin
      errors++;
      $display("FAIL rst_ready got %b exp 11", req_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_dual_enq();
    req_valid = 2'b11;
    req_data[0] = 32'hA0;
    req_data[1] = 32'hA1;
    #1;
    checks++;
    if (enq_mask !== 8'b0010_0001) begin
      errors++;
      $display("FAIL dual_mask got %b exp 00100001", enq_mask);
    end
    checks++;
    if (enq_fire !== 2'b11) begin
      errors++;
      $display("FAIL dual_fire got %b exp 11", enq_fire);
    end
    step();
    idle();
    #1;
    checks++;
    if (entry_vld !== 4'b0011 || count !== 3'd2) begin
      errors++;
      $display("FAIL dual_next got vld=%b cnt=%0d exp 0011/2",
               entry_vld, count);
    end
  endtask

  task automatic test_fill();
    req_valid = 2'b01;
    req_data[0] = 32'hA2;
    #1;
    checks++;
    if (enq_mask[0] !== 4'b0100) begin
      errors++;
      $display("FAIL fill_m2 got %b exp 0100", enq_mask[0]);
    end
    step();
    req_valid = 2'b11;
    req_data[0] = 32'hA3;
    req_data[1] = 32'hA4;
    #1;
    checks++;
    if (req_ready !== 2'b01 || enq_fire !== 2'b01) begin
      errors++;
      $display("FAIL fill_rdy got rdy=%b fire=%b exp 01/01",
               req_ready, enq_fire);
    end
    checks++;
    if (enq_mask !== 8'b0000_1000) begin
      errors++;
      $display("FAIL fill_m3 got %b exp 00001000", enq_mask);
    end
    step();
    #1;
    checks++;
    if (full !== 1'b1 || req_ready !== 2'b00 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full got f=%b rdy=%b cnt=%0d exp 1/00/4",
               full, req_ready, count);
    end
  endtask

  task automatic test_deq_full();
    req_valid = 2'b11;
    deq_fire = 1'b1;
    deq_mask = 4'b0100;
    #1;
    checks++;
    if (deq_data !== 32'hA2) begin
      errors++;
      $display("FAIL dfull_data got %h exp a2", deq_data);
    end
    checks++;
    if (req_ready !== 2'b00 || enq_mask !== 8'h00) begin
      errors++;
      $display("FAIL dfull_rdy got rdy=%b m=%b exp 00/0",
               req_ready, enq_mask);
    end
    step();
    idle();
    #1;
    checks++;
    if (count !== 3'd3 || enq_mask[0] !== 4'b0100) begin
      errors++;
      $display("FAIL dfull_next got cnt=%0d m0=%b exp 3/0100",
               count, enq_mask[0]);
    end
  endtask

  task automatic test_deq_enq_same();
    do_reset();
    req_valid = 2'b01;
    req_data[0] = 32'hA5;
    step();
    req_data[0] = 32'hB0;
    deq_fire = 1'b1;
    deq_mask = 4'b0001;
    #1;
    checks++;
    if (enq_mask[0] !== 4'b0010) begin
      errors++;
      $display("FAIL same_mask got %b exp 0010", enq_mask[0]);
    end
    checks++;
    if (deq_data !== 32'hA5) begin
      errors++;
      $display("FAIL same_data got %h exp a5", deq_data);
    end
    step();
    idle();
    #1;
    checks++;
    if (entry_vld !== 4'b0010 || count !== 3'd1) begin
      errors++;
      $display("FAIL same_next got vld=%b cnt=%0d exp 0010/1",
               entry_vld, count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b11;
    step();
    req_valid = 2'b01;
    step();
    idle();
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL mid_pre got cnt=%0d exp 3", count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (entry_vld !== 4'b0000 || count !== 3'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got vld=%b cnt=%0d e=%b exp 0/0/1",
               entry_vld, count, empty);
    end
    #1;
    rst_n = 1'b1;
    step();
    checks++;
    if (enq_mask[0] !== 4'b0001) begin
      errors++;
      $display("FAIL mid_after got %b exp 0001", enq_mask[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] mvld;
    logic [31:0] mdata[4];
    logic [3:0] taken;
    logic [1:0][3:0] emask;
    logic [1:0] erdy;
    logic [3:0] nvld;
    int ncnt, nv, idx, freen;
    bit found;
    exp_t ex;
    do_reset();
    mvld = '0;
    for (int c = 0; c < 10000; c++) begin
      nv = $urandom_range(0, 2);
      req_valid = (nv == 2) ? 2'b11 : (nv == 1) ? 2'b01 : 2'b00;
      req_data[0] = $urandom;
      req_data[1] = $urandom;
      deq_fire = 1'b0;
      deq_mask = 4'b0000;
      idx = 0;
      if (mvld != 4'b0000 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 3);
        while (!mvld[idx]) idx = (idx + 1) % 4;
        deq_fire = 1'b1;
        deq_mask = 4'b0001 << idx;
      end
      freen = 4 - $countones(mvld);
      taken = '0;
      emask = '0;
      erdy = '0;
      for (int j = 0; j < 2; j++) begin
        if (freen > j) begin
          erdy[j] = 1'b1;
          found = 0;
          for (int e = 0; e < 4; e++) begin
            if (!mvld[e] && !taken[e] && !found) begin
              emask[j][e] = 1'b1;
              found = 1;
            end
          end
          taken = taken | emask[j];
        end
      end
      #1;
      checks++;
      if (req_ready !== erdy || enq_mask !== emask) begin
        errors++;
        $display("FAIL rnd_alloc c=%0d got rdy=%b m=%b exp %b/%b",
                 c, req_ready, enq_mask, erdy, emask);
      end
      if (deq_fire) begin
        checks++;
        if (deq_data !== mdata[idx]) begin
          errors++;
          $display("FAIL rnd_deq c=%0d got %h exp %h",
                   c, deq_data, mdata[idx]);
        end
      end
      nvld = mvld & ~deq_mask;
      for (int j = 0; j < 2; j++) begin
        if (req_valid[j] && erdy[j]) begin
          nvld = nvld | emask[j];
          for (int e = 0; e < 4; e++) begin
            if (emask[j][e]) mdata[e] = req_data[j];
          end
        end
      end
      ncnt = $countones(nvld);
      ex.vld = nvld;
      ex.cnt = 3'(ncnt);
      sb.push_back(ex);
      mvld = nvld;
      @(posedge clk);
      #1;
      ex = sb.pop_front();
      checks++;
      if (entry_vld !== ex.vld || count !== ex.cnt) begin
        errors++;
        $display("FAIL rnd_state c=%0d got vld=%b cnt=%0d exp %b/%0d",
                 c, entry_vld, count, ex.vld, ex.cnt);
      end
      checks++;
      if ($countones(entry_vld) != int'(count)) begin
        errors++;
        $display("FAIL rnd_pop c=%0d got cnt=%0d pop=%0d",
                 c, count, $countones(entry_vld));
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    test_reset();
    test_dual_enq();
    test_fill();
    test_deq_full();
    test_deq_enq_same();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
